// File: rtl/pipe_track.sv
// Scrolling pipe manager: keeps the right edge of each pipe, scrolls and wraps them on
// frame ticks, tracks the pipe ahead of the bird and keeps a saturating score.
module pipe_track #(
  parameter int NUM_PIPES = 4,
  parameter int XW        = 10,
  parameter int PIPE_W    = 80,
  parameter int SPACING   = 160,
  parameter int BIRD_X    = 320,
  parameter int SCORE_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Start,
  input  logic                         Stop,
  input  logic                         Ack,
  input  logic                         tick,
  input  logic [2:0]                   speed,
  input  logic [$clog2(NUM_PIPES)-1:0] rel_idx,
  output logic [XW-1:0]                x_left,
  output logic [XW-1:0]                x_right,
  output logic [$clog2(NUM_PIPES)-1:0] out_pipe,
  output logic [SCORE_W-1:0]           Score,
  output logic                         passed,
  output logic                         Q_Initial,
  output logic                         Q_Run,
  output logic                         Q_Stop
);

  localparam int IW     = $clog2(NUM_PIPES);
  localparam int PERIOD = NUM_PIPES * SPACING;

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2} state_t;

  function automatic logic [XW-1:0] init_r(input int i);
    return XW'(PIPE_W + i * SPACING);
  endfunction

  // First pipe whose starting right edge is at or beyond the bird.
  function automatic int first_ahead();
    int res;
    res = 0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (PIPE_W + i * SPACING >= BIRD_X) res = i;
    end
    return res;
  endfunction

  localparam logic [IW-1:0] INIT_OUT = IW'(first_ahead());

  state_t        state, state_next;
  logic [XW-1:0] r      [NUM_PIPES];
  logic [XW-1:0] r_step [NUM_PIPES];
  logic [IW-1:0] sel;
  logic          adv;

  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (Start) state_next = S_RUN;  else state_next = S_INIT;
      S_RUN:   if (Stop)  state_next = S_STOP; else state_next = S_RUN;
      S_STOP:  if (Ack)   state_next = S_INIT; else state_next = S_STOP;
      default: state_next = S_INIT;
    endcase
  end

  // Positions never reach 0: stepping at or past the left edge wraps by one period.
  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (r[i] > XW'(speed)) r_step[i] = r[i] - XW'(speed);
      else                   r_step[i] = r[i] - XW'(speed) + XW'(PERIOD);
    end
  end

  assign adv = r_step[out_pipe] < XW'(BIRD_X);

  always_ff @(posedge clk) begin
    if (reset || state == S_INIT || (state == S_STOP && Ack)) begin
      for (int i = 0; i < NUM_PIPES; i++) r[i] <= init_r(i);
      out_pipe <= INIT_OUT;
      Score    <= '0;
      passed   <= 1'b0;
    end else if (state == S_RUN && tick && !Stop) begin
      for (int i = 0; i < NUM_PIPES; i++) r[i] <= r_step[i];
      if (adv) begin
        out_pipe <= out_pipe + IW'(1);
        if (Score != {SCORE_W{1'b1}}) Score <= Score + SCORE_W'(1);
        passed <= 1'b1;
      end else begin
        passed <= 1'b0;
      end
    end else begin
      passed <= 1'b0;
    end
  end

  assign sel       = out_pipe + rel_idx;
  assign x_right   = r[sel];
  assign x_left    = (r[sel] > XW'(PIPE_W)) ? r[sel] - XW'(PIPE_W) : '0;
  assign Q_Initial = (state == S_INIT);
  assign Q_Run     = (state == S_RUN);
  assign Q_Stop    = (state == S_STOP);

endmodule

// File: tb/tb_pipe_track.sv
// Bench for pipe_track: a behavioural model feeds an expectation queue each cycle, plus
// constant checks for the reset table, first pass, wrap, stop/ack, saturation and pause.
module tb_pipe_track;

  logic       clk = 1'b0;
  logic       reset, Start, Stop, Ack, tick;
  logic [2:0] speed;
  logic [1:0] rel_idx;
  logic [9:0] x_left, x_right, x_left2, x_right2;
  logic [1:0] out_pipe, out_pipe2;
  logic [7:0] Score;
  logic [1:0] Score2;
  logic       passed, passed2;
  logic       Q_Initial, Q_Run, Q_Stop, Q_Initial2, Q_Run2, Q_Stop2;

  int checks = 0;
  int errors = 0;

  pipe_track dut (
    .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Ack(Ack), .tick(tick),
    .speed(speed), .rel_idx(rel_idx), .x_left(x_left), .x_right(x_right),
    .out_pipe(out_pipe), .Score(Score), .passed(passed),
    .Q_Initial(Q_Initial), .Q_Run(Q_Run), .Q_Stop(Q_Stop));

  pipe_track #(.SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Ack(Ack), .tick(tick),
    .speed(speed), .rel_idx(rel_idx), .x_left(x_left2), .x_right(x_right2),
    .out_pipe(out_pipe2), .Score(Score2), .passed(passed2),
    .Q_Initial(Q_Initial2), .Q_Run(Q_Run2), .Q_Stop(Q_Stop2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       q;
    logic [1:0]       op;
    logic [7:0]       sc;
    logic [1:0]       sc2;
    logic             pass;
    logic [3:0][9:0]  pos;
  } exp_t;

  typedef struct {
    int rel;
    int xl;
    int xr;
  } init_vec_t;

  exp_t      q[$];
  init_vec_t tbl[4];

  int m_pos[4];
  int m_op, m_sc, m_sc2, m_st, m_pass;
  int pcnt, n2;
  int sat_sc[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_load();
    for (int i = 0; i < 4; i++) m_pos[i] = 80 + 160 * i;
    m_op  = 2;
    m_sc  = 0;
    m_sc2 = 0;
  endtask

  task automatic model_step(input bit st_i, input bit sp, input bit ak, input bit tk,
                            input int spd, input bit rs);
    m_pass = 0;
    if (rs) begin
      m_load();
      m_st = 0;
    end else if (m_st == 0) begin
      m_load();
      if (st_i) m_st = 1;
    end else if (m_st == 1) begin
      if (sp) m_st = 2;
      else if (tk) begin
        for (int i = 0; i < 4; i++) m_pos[i] = ((m_pos[i] - spd - 1 + 640) % 640) + 1;
        if (m_pos[m_op] < 320) begin
          m_op = (m_op + 1) % 4;
          if (m_sc < 255) m_sc++;
          if (m_sc2 < 3) m_sc2++;
          m_pass = 1;
        end
      end
    end else if (ak) begin
      m_load();
      m_st = 0;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.q    = (m_st == 0) ? 3'b100 : (m_st == 1) ? 3'b010 : 3'b001;
    e.op   = 2'(m_op);
    e.sc   = 8'(m_sc);
    e.sc2  = 2'(m_sc2);
    e.pass = (m_pass != 0);
    for (int i = 0; i < 4; i++) e.pos[i] = 10'(m_pos[i]);
    return e;
  endfunction

  // One clock: drive inputs, queue the model's expectation, then compare after the edge.
  task automatic cyc(input bit st_i, input bit sp, input bit ak, input bit tk,
                     input int spd, input bit rs);
    exp_t e;
    int   idx, el;
    Start = st_i; Stop = sp; Ack = ak; tick = tk; speed = 3'(spd); reset = rs;
    model_step(st_i, sp, ak, tk, spd, rs);
    q.push_back(snap());
    @(posedge clk);
    #1;
    Start = 1'b0; Stop = 1'b0; Ack = 1'b0; tick = 1'b0; reset = 1'b0;
    e = q.pop_front();
    chk("state", {Q_Initial, Q_Run, Q_Stop}, e.q);
    chk("state_w2", {Q_Initial2, Q_Run2, Q_Stop2}, e.q);
    chk("out_pipe", out_pipe, e.op);
    chk("score", Score, e.sc);
    chk("score_w2", Score2, e.sc2);
    chk("passed", passed, e.pass);
    chk("passed_w2", passed2, e.pass);
    if (passed) pcnt++;
    if (passed2) begin
      if (n2 < 8) sat_sc[n2] = Score2;
      n2++;
    end
    for (int r = 0; r < 4; r++) begin
      rel_idx = 2'(r);
      #1;
      idx = (e.op + r) % 4;
      el  = (e.pos[idx] > 80) ? e.pos[idx] - 80 : 0;
      chk("x_right", x_right, e.pos[idx]);
      chk("x_left", x_left, el);
    end
  endtask

  task automatic check_pipe(input int p, input int er, input int el);
    rel_idx = 2'((p - m_op + 4) % 4);
    #1;
    chk("pipe_right", x_right, er);
    chk("pipe_left", x_left, el);
  endtask

  task automatic check_init_table();
    chk("init_out_pipe", out_pipe, 2);
    for (int k = 0; k < 4; k++) begin
      rel_idx = 2'(tbl[k].rel);
      #1;
      chk("init_x_left", x_left, tbl[k].xl);
      chk("init_x_right", x_right, tbl[k].xr);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    tbl[0] = '{rel: 0, xl: 320, xr: 400};
    tbl[1] = '{rel: 1, xl: 480, xr: 560};
    tbl[2] = '{rel: 2, xl: 0,   xr: 80};
    tbl[3] = '{rel: 3, xl: 160, xr: 240};
    reset = 1'b1; Start = 1'b0; Stop = 1'b0; Ack = 1'b0; tick = 1'b0;
    speed = 3'd0; rel_idx = 2'd0;
    m_st = 0; m_pass = 0; m_load();
    pcnt = 0; n2 = 0;

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("reset_q_initial", Q_Initial, 1);
    chk("reset_score", Score, 0);
    check_init_table();

    // First pass at speed 1: pipe 2 crosses the bird on tick 81.
    cyc(1, 0, 0, 0, 0, 0);
    pcnt = 0;
    for (int k = 1; k <= 81; k++) begin
      cyc(0, 0, 0, 1, 1, 0);
      if (k == 80) chk("no_pulse_before_81", pcnt, 0);
      if (k < 81) cyc(0, 0, 0, 0, 1, 0);
    end
    chk("pass1_out_pipe", out_pipe, 3);
    chk("pass1_score", Score, 1);
    chk("pass1_pulses", pcnt, 1);
    check_pipe(2, 319, 239);

    // Wrap at speed 3.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 26; k++) cyc(0, 0, 0, 1, 3, 0);
    check_pipe(0, 2, 0);
    cyc(0, 0, 0, 1, 3, 0);
    check_pipe(0, 639, 559);
    check_pipe(1, 159, 79);
    rel_idx = 2'((1 - m_op + 4) % 4);
    #1;
    d = x_right;
    rel_idx = 2'((0 - m_op + 4) % 4);
    #1;
    chk("wrap_spacing", (d - int'(x_right) + 640) % 640, 160);

    // Stop together with tick, ticks ignored in STOP, then Ack reloads.
    cyc(0, 1, 0, 1, 3, 0);
    chk("stop_q_stop", Q_Stop, 1);
    check_pipe(0, 639, 559);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 3, 0);
    check_pipe(0, 639, 559);
    cyc(0, 0, 1, 0, 0, 0);
    chk("ack_q_initial", Q_Initial, 1);
    chk("ack_score", Score, 0);
    check_init_table();

    // Saturation on the 2-bit score instance.
    cyc(1, 0, 0, 0, 0, 0);
    n2 = 0;
    for (int k = 0; k < 400 && n2 < 5; k++) cyc(0, 0, 0, 1, 7, 0);
    chk("sat_pulses", n2, 5);
    chk("sat_score_1", sat_sc[0], 1);
    chk("sat_score_2", sat_sc[1], 2);
    chk("sat_score_3", sat_sc[2], 3);
    chk("sat_score_4", sat_sc[3], 3);
    chk("sat_score_5", sat_sc[4], 3);
    chk("wide_score_5", Score, 5);

    // Reset in the middle of RUN, then paused ticks.
    cyc(0, 0, 0, 1, 7, 1);
    chk("midrun_reset_q_initial", Q_Initial, 1);
    chk("midrun_reset_score", Score, 0);
    check_init_table();
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 0, 0);
    chk("pause_q_run", Q_Run, 1);
    chk("pause_score", Score, 0);
    check_init_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_track.md
# pipe_track

Parametrised scrolling-obstacle manager for Flappy-VGA. Holds the X edges of `NUM_PIPES` pipes, scrolls them left by a programmable speed on each frame tick, and wraps them back to the right. Also tracks the pipe currently in front of the bird, keeps a saturating score and provides a relative-order read port. It sits between the game FSM (Start/Stop/Ack) and the obstacle/collision and VGA draw logic.

## Interface
- `NUM_PIPES`, 4: pipe count; power of 2, ≥2.
- `XW`, 10: coordinate width; must hold `PERIOD = NUM_PIPES*SPACING`.
- `PIPE_W`, 80: pipe width in pixels.
- `SPACING`, 160: right-edge to right-edge distance between adjacent pipes.
- `BIRD_X`, 320: bird X; a pipe is passed when its right edge drops below this.
- `SCORE_W`, 8: score width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `Start` in 1: leave INITIAL.
- `Stop` in 1: game over; freeze.
- `Ack` in 1: leave STOP and return to INITIAL.
- `tick` in 1: one-cycle frame-advance strobe.
- `speed` in 3: pixels moved per tick; 0 means paused.
- `rel_idx` in log2(NUM_PIPES): read index relative to `out_pipe`; 0 is the current pipe.
- `x_left` out XW: left edge of pipe `(out_pipe+rel_idx) mod NUM_PIPES`.
- `x_right` out XW: right edge of the same pipe.
- `out_pipe` out log2(NUM_PIPES): absolute index of the pipe in scope.
- `Score` out SCORE_W: pipes passed; saturating.
- `passed` out 1: one-cycle pulse when a pipe is passed.
- `Q_Initial`, `Q_Run`, `Q_Stop` out 1 each: one-hot state.

## Operation
- Per-pipe state is the right edge `R[i]`, XW bits. Derived edges:
  - `x_right = R`.
  - `x_left = (R > PIPE_W) ? R - PIPE_W : 0`, clamped at the screen edge.
- Initial load: `R[i] = PIPE_W + i*SPACING`, giving 80/240/400/560 at defaults.
- Initial `out_pipe` is the smallest `i` with `PIPE_W + i*SPACING >= BIRD_X`; 2 at defaults. Resolve it at elaboration.
- States:
  - INITIAL: hold the initial load, `Score = 0`. `Start` → RUN.
  - RUN: on `tick` with `!Stop`, step every pipe: `R' = (R > speed) ? R - speed : R - speed + PERIOD`. `R` is never 0.
  - RUN advance: in the same cycle, if the stepped `R'[out_pipe] < BIRD_X`, then `out_pipe` increments mod `NUM_PIPES`, `Score` increments (holds at all-ones), and `passed` = 1 next cycle. At most one advance per tick.
  - RUN: `Stop` → STOP. `Stop` has priority over `tick`: no step, no score that cycle.
  - STOP: positions, `out_pipe` and `Score` frozen. `Ack` → INITIAL, which reloads all state.
- `tick` is ignored outside RUN. With `speed == 0`, RUN ticks change nothing.
- Constraints: `7 < SPACING`, `7 < PIPE_W`, `BIRD_X < PERIOD`.

## Timing
- Reset values: `Q_Initial = 1`, others 0; `R` at the initial load; `out_pipe` at its initial value; `Score = 0`; `passed = 0`.
- `reset` overrides everything, including mid-RUN and mid-STOP. Positions reload on the next edge.
- State transitions take effect one cycle after the qualifying input is sampled.
- The position step, `out_pipe` advance and `Score` update all land on the same edge after the tick cycle.
- `x_left`/`x_right` are combinational from registered state and `rel_idx`, with no added latency.
- `passed` is registered, high exactly one cycle, aligned with the updated `Score`.
- Wrap example: `R = 2`, `speed = 3` gives `R' = 639`. The compare uses `R'`, never the pre-step value.

## Test plan
- Reset: `Q_Initial = 1`, `out_pipe = 2`, `Score = 0`. `rel_idx = 0` gives `x_left = 320`, `x_right = 400`. `rel_idx = 2` gives `x_left = 0`, `x_right = 80` (clamp).
- Start, then `speed = 1` for 81 ticks: after tick 81, `R[2] = 319`, `out_pipe = 3`, `Score = 1`, `passed` pulses once. Ticks 1–80 produce no pulse.
- Wrap: `speed = 3`, pipe 0 from 80. After 26 ticks `R[0] = 2`. Tick 27 gives `R[0] = 639`, `x_left = 559`. Spacing to pipe 1 mod 640 stays 160.
- `Stop` asserted together with `tick`: no position change, `Q_Stop = 1` next cycle. Later ticks are ignored. `Ack` → `Q_Initial`, initial load restored, `Score = 0`.
- Saturation with `SCORE_W = 2`: run 5 passes. `Score` reads 1,2,3,3,3 and `passed` pulses 5 times.
- Reset mid-RUN, and `speed = 0` ticks in RUN: reset reloads all state next edge. Zero-speed ticks leave `R`, `Score` and `out_pipe` unchanged.
